// File: rtl/cla_multiword_sequencer.sv
// cla_multiword_sequencer: wide adder that reuses one NUMBITS-wide
// carry-look-ahead slice over WORDS clock cycles. The result is built
// slice by slice, and the carry is registered between slices.
// Optional feature macro: CLA_SEQ_OVERFLOW_EN adds a registered
// signed-overflow output.

// Single NUMBITS-wide carry-look-ahead adder slice (purely combinational).
module carry_look_ahead_adder #(
    parameter int NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] a_i,
    input  logic [NUMBITS-1:0] b_i,
    input  logic               carry_i,
    output logic [NUMBITS-1:0] sum_o,
    output logic               carry_o
);

    logic [NUMBITS-1:0] gen;
    logic [NUMBITS-1:0] prop;
    logic [NUMBITS:0]   carries;
    logic               term;
    logic               chain;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Expand every carry as a flat sum of generate/propagate products.
    // No carry depends on the previous one, which keeps the slice shallow.
    always_comb begin
        carries    = '0;
        term       = 1'b0;
        chain      = 1'b0;
        carries[0] = carry_i;
        for (int i = 0; i < NUMBITS; i++) begin
            term  = gen[i];
            chain = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term  = term | (chain & gen[j]);
                chain = chain & prop[j];
            end
            carries[i+1] = term | (chain & carry_i);
        end
    end

    assign sum_o   = prop ^ carries[NUMBITS-1:0];
    assign carry_o = carries[NUMBITS];

endmodule

// Sequencer that streams the operand slices through the shared adder.
module cla_multiword_sequencer #(
    parameter int NUMBITS = 8,
    parameter int WORDS   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUMBITS*WORDS-1:0]   a,
    input  logic [NUMBITS*WORDS-1:0]   b,
    input  logic                       carryin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUMBITS*WORDS-1:0]   sum,
    output logic                       carryout,
`ifdef CLA_SEQ_OVERFLOW_EN
    output logic                       overflow,
`endif
    output logic                       busy
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic                            carry_q, carry_d;
    logic [WORDS-1:0][NUMBITS-1:0]   a_q, a_d;
    logic [WORDS-1:0][NUMBITS-1:0]   b_q, b_d;
    logic [WORDS-1:0][NUMBITS-1:0]   sum_q, sum_d;
    logic                            cout_q, cout_d;
`ifdef CLA_SEQ_OVERFLOW_EN
    logic                            ovf_q, ovf_d;
`endif

    logic [NUMBITS-1:0]              claA;
    logic [NUMBITS-1:0]              claB;
    logic [NUMBITS-1:0]              claSum;
    logic                            claCout;
    logic                            lastSlice;

    // The shared slice always sees the operand words picked by the index.
    assign claA      = a_q[idx_q];
    assign claB      = b_q[idx_q];
    assign lastSlice = (idx_q == LAST_IDX);

    carry_look_ahead_adder #(
        .NUMBITS (NUMBITS)
    ) u_cla (
        .a_i     (claA),
        .b_i     (claB),
        .carry_i (carry_q),
        .sum_o   (claSum),
        .carry_o (claCout)
    );

    // State and datapath registers. The reset is asynchronous and active low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic: capture operands in IDLE, do one slice per cycle
    // in RUN, and hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carryin;
                    idx_d   = '0;
                    sum_d   = '0;
`ifdef CLA_SEQ_OVERFLOW_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = claSum;
                carry_d      = claCout;
                if (lastSlice) begin
                    cout_d  = claCout;
                    idx_d   = '0;
`ifdef CLA_SEQ_OVERFLOW_EN
                    ovf_d   = (a_q[WORDS-1][NUMBITS-1] == b_q[WORDS-1][NUMBITS-1]) &&
                              (claSum[NUMBITS-1] != a_q[WORDS-1][NUMBITS-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign carryout  = cout_q;
`ifdef CLA_SEQ_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: doc/cla_multiword_sequencer.md
# cla_multiword_sequencer

Multi-cycle wide adder that streams WORDS slices of NUMBITS bits through one shared `carry_look_ahead_adder` instance. Each slice's carry is registered into the next slice, one slice per clock. The block sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides. It lets narrow CLA hardware perform NUMBITS*WORDS-bit additions, trading latency for area.

## Interface
- NUMBITS, 8: width of the shared CLA slice.
- WORDS, 4: number of slices per operation; must be ≥ 2. Operand width W = NUMBITS*WORDS.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- carryin  input  1  carry into slice 0.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result, (a+b+carryin) mod 2^W.
- carryout  output  1  registered carry out of the top slice.
- busy  output  1  high in RUN or DONE.
- overflow  output  1  signed overflow; present only with CLA_SEQ_OVERFLOW_EN.

## Operation
- Reset (reset=0, asynchronous): state=IDLE, slice index=0, carry register=0, sum=0, carryout=0, overflow=0, out_valid=0, busy=0, in_ready=1.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and carryin into internal registers; carry register←carryin, index←0, clear sum; go to RUN.
- RUN:
  - The CLA is fed A_reg/B_reg slice [index*NUMBITS +: NUMBITS] and the carry register.
  - Each clock: sum slice[index]←CLA result; carry register←CLA carryout; index←index+1.
  - When index==WORDS-1 at the edge: carryout←CLA carryout, index←0, go to DONE.
- DONE:
  - out_valid=1. sum and carryout are held stable until the handshake.
  - On out_ready: go to IDLE. out_valid deasserts on the next edge.
- Input handling:
  - in_valid outside IDLE is ignored; no queuing.
  - Changes on a/b after capture have no effect.
- Arithmetic: unsigned modulo 2^W. carryout is the true bit W of a+b+carryin.
- Index counter width is $clog2(WORDS); it wraps only through the explicit reset to 0 on the transition to DONE.

## Timing
- Accept edge = cycle 0. RUN occupies edges 1..WORDS. out_valid is high after edge WORDS, i.e. latency = WORDS cycles from accept to out_valid.
- Minimum initiation interval is WORDS+2 cycles: accept, WORDS RUN edges, DONE handshake edge, return to IDLE.
- out_ready held high in DONE: out_valid lasts exactly 1 cycle.
- out_ready low: DONE is held indefinitely with all outputs frozen.
- Simultaneous in_valid and out_ready in DONE: only the result handshake occurs. The operand is accepted no earlier than the following IDLE cycle.
- Reset asserted mid-RUN or in DONE: the operation is aborted and all outputs immediately take reset values. The first accept is possible on the first edge after reset release.
- The CLA path is combinational within one cycle; the slice critical path is a single NUMBITS CLA plus the sum write.

## Configuration
- CLA_SEQ_OVERFLOW_EN defined:
  - Port `overflow` exists.
  - Computed on the final RUN edge as (a[W-1]==b[W-1]) && (sum bit W-1 ≠ a[W-1]).
  - Registered, valid with out_valid, held in DONE, cleared by reset and by accept.
- CLA_SEQ_OVERFLOW_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
Defaults unless stated: NUMBITS=8, WORDS=4, carryin=0.
- a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, carryout=1, out_valid rises exactly 4 cycles after accept.
- a=0x12345678, b=0x11111111 → sum=0x23456789, carryout=0.
- carryin=1, a=0x000000FF, b=0 → sum=0x00000100, carryout=0; checks the carry chaining across slices.
- Backpressure: out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands → sum/out_valid stable, in_ready=0, new operands not captured. On out_ready=1, out_valid drops next cycle, then the new operand is accepted.
- reset pulsed low while index=2 in RUN → sum=0, out_valid=0, in_ready=1 immediately. After release, 0x0000FFFF+0x00000001 → 0x00010000.
- With CLA_SEQ_OVERFLOW_EN: 0x7FFFFFFF+0x00000001 → overflow=1, carryout=0. 0xFFFFFFFF+0x00000001 → overflow=0, carryout=1. Without the macro, the build elaborates with no overflow port.
